// File: rtl/ddr_wr_pkg.sv
// Shared types and constants for the DDR write-burst master.
package ddr_wr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AW   = 2'd1,
      ST_W    = 2'd2,
      ST_B    = 2'd3
   } wr_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Bytes moved by one burst of len beats on a data_w-bit bus.
   function automatic logic [31:0] burst_bytes(input int unsigned len,
                                               input int unsigned data_w);
      return 32'(len * (data_w / 8));
   endfunction

endpackage

// File: rtl/ddr_wr_addr_gen.sv
// Ring offset tracker: advances one burst per completed write response.
module ddr_wr_addr_gen #(
   parameter int unsigned ADDR_W      = 32,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] RING_BYTES  = 32'h1000_0000,
   parameter logic [31:0] BURST_BYTES = 32'd512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_advance,
   output logic [ADDR_W-1:0] o_addr_c
);

   logic [31:0] r_offset;
   logic [31:0] w_offset_inc;

   assign w_offset_inc = r_offset + BURST_BYTES;

   // Wrap exactly at the ring end; RING_BYTES is a whole number of bursts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_offset <= '0;
      end else if (i_advance) begin
         r_offset <= (w_offset_inc == RING_BYTES) ? 32'd0 : w_offset_inc;
      end
   end

   assign o_addr_c = ADDR_W'(BASE_ADDR + r_offset);

endmodule

// File: rtl/ddr_write_burst_ctrl.sv
// AXI4 write-burst master draining a FWFT FIFO into a DDR ring, one burst outstanding.
module ddr_write_burst_ctrl
   import ddr_wr_pkg::*;
#(
   parameter int unsigned C_M_AXI_DATA_WIDTH = 256,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned FIFO_DATA_WIDTH    = 192,
   parameter int unsigned C_M_AXI_BURST_LEN  = 16,
   parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
   parameter logic [31:0] RING_BYTES         = 32'h1000_0000
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   input  logic                              ctrl_wr_en,
   input  logic [FIFO_DATA_WIDTH-1:0]        fifo_dout,
   input  logic                              fifo_empty,
   input  logic [9:0]                        fifo_rd_data_count,
   output logic                              fifo_rd_en,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [7:0]                        M_AXI_AWLEN,
   output logic [2:0]                        M_AXI_AWSIZE,
   output logic [1:0]                        M_AXI_AWBURST,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WLAST,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [31:0]                       wr_burst_cnt,
   output logic                              bresp_err,
   output logic                              busy
);

   localparam int unsigned STRB_W      = C_M_AXI_DATA_WIDTH / 8;
   localparam logic [31:0] BURST_BYTES = burst_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH);
   localparam logic [7:0]  LAST_BEAT   = 8'(C_M_AXI_BURST_LEN - 1);
   localparam logic [2:0]  AXI_SIZE    = 3'($clog2(STRB_W));

   wr_state_e                         r_state;
   wr_state_e                         w_state_nxt;
   logic [7:0]                        r_beat_cnt;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     r_awaddr;
   logic [31:0]                       r_burst_cnt;
   logic                              r_bresp_err;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     w_addr;
   logic                              w_start;
   logic                              w_wvalid;
   logic                              w_bready;
   logic                              w_w_hs;
   logic                              w_b_hs;
   logic                              w_in_w;

   assign w_start = (r_state == ST_IDLE) && ctrl_wr_en &&
                    (32'(fifo_rd_data_count) >= 32'(C_M_AXI_BURST_LEN));
   assign w_in_w  = (r_state == ST_W);
   assign w_w_hs  = w_wvalid && M_AXI_WREADY;
   assign w_b_hs  = w_bready && M_AXI_BVALID;

   ddr_wr_addr_gen #(
      .ADDR_W      (C_M_AXI_ADDR_WIDTH),
      .BASE_ADDR   (BASE_ADDR),
      .RING_BYTES  (RING_BYTES),
      .BURST_BYTES (BURST_BYTES)
   ) u_addr_gen (
      .clk       (M_AXI_ACLK),
      .rst_n     (M_AXI_ARESETN),
      .i_advance (w_b_hs),
      .o_addr_c  (w_addr)
   );

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-state channel strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_wvalid    = 1'b0;
      w_bready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_state_nxt = ST_AW;
         end
         ST_AW: begin
            if (M_AXI_AWREADY) w_state_nxt = ST_W;
         end
         ST_W: begin
            w_wvalid = !fifo_empty;
            if (w_wvalid && M_AXI_WREADY && (r_beat_cnt == LAST_BEAT)) w_state_nxt = ST_B;
         end
         ST_B: begin
            w_bready = 1'b1;
            if (M_AXI_BVALID) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Address capture, beat counting and response bookkeeping.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         r_beat_cnt  <= '0;
         r_awaddr    <= '0;
         r_burst_cnt <= '0;
         r_bresp_err <= 1'b0;
      end else begin
         if (w_start) r_awaddr <= w_addr;
         if (w_w_hs) begin
            r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? 8'd0 : r_beat_cnt + 8'd1;
         end
         if (w_b_hs) begin
            r_burst_cnt <= r_burst_cnt + 32'd1;
            r_bresp_err <= r_bresp_err | (M_AXI_BRESP != AXI_RESP_OKAY);
         end
      end
   end

   assign M_AXI_AWADDR  = r_awaddr;
   assign M_AXI_AWLEN   = LAST_BEAT;
   assign M_AXI_AWSIZE  = AXI_SIZE;
   assign M_AXI_AWBURST = AXI_BURST_INCR;
   assign M_AXI_AWVALID = (r_state == ST_AW);
   assign M_AXI_WDATA   = w_in_w ? C_M_AXI_DATA_WIDTH'(fifo_dout) : '0;
   assign M_AXI_WSTRB   = w_in_w ? {STRB_W{1'b1}} : '0;
   assign M_AXI_WVALID  = w_wvalid;
   assign M_AXI_WLAST   = w_wvalid && (r_beat_cnt == LAST_BEAT);
   assign M_AXI_BREADY  = w_bready;
   assign fifo_rd_en    = w_w_hs;
   assign wr_burst_cnt  = r_burst_cnt;
   assign bresp_err     = r_bresp_err;
   assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ddr_write_burst_ctrl.sv
// Scoreboard bench: FWFT FIFO + AXI slave model, expected beats queued at push time.
`timescale 1ns/1ps
module tb_ddr_write_burst_ctrl;

   localparam int unsigned DW   = 256;
   localparam int unsigned AW   = 32;
   localparam int unsigned FW   = 192;
   localparam int unsigned LEN  = 16;
   localparam logic [31:0] BASE = 32'h0000_2000;
   localparam logic [31:0] BB   = 32'(LEN * DW / 8);
   localparam logic [31:0] RING = 2 * BB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ctrl_wr_en = 1'b0;
   logic [FW-1:0] fifo_dout = '0;
   logic          fifo_empty = 1'b1;
   logic [9:0]    fifo_rd_data_count = '0;
   logic          fifo_rd_en;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          awvalid;
   logic          awready = 1'b0;
   logic [DW-1:0] wdata;
   logic [DW/8-1:0] wstrb;
   logic          wlast, wvalid;
   logic          wready = 1'b0;
   logic [1:0]    bresp = 2'b00;
   logic          bvalid = 1'b0;
   logic          bready;
   logic [31:0]   wr_burst_cnt;
   logic          bresp_err, busy;

   always #5 clk = ~clk;

   ddr_write_burst_ctrl #(
      .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .FIFO_DATA_WIDTH(FW),
      .C_M_AXI_BURST_LEN(LEN), .BASE_ADDR(BASE), .RING_BYTES(RING)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .ctrl_wr_en(ctrl_wr_en),
      .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_data_count(fifo_rd_data_count),
      .fifo_rd_en(fifo_rd_en),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
      .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .wr_burst_cnt(wr_burst_cnt), .bresp_err(bresp_err), .busy(busy)
   );

   // Reference model / scoreboard state
   logic [FW-1:0] fifo_q[$];
   logic [DW-1:0] exp_w[$];
   logic [31:0]   aw_log[$];
   int  n_vec = 0, n_err = 0;
   int  aw_hs_cnt, w_hs_cnt, b_hs_cnt, beats_in_burst;
   int  bubble_left, aw_delay, b_delay, wready_mode, err_burst;
   int  aw_wait, b_wait;
   bit  pop_pend, last_pend, b_hs_pend, b_active, outstanding;
   logic model_err;
   bit  prev_aw_stall, prev_w_stall;
   logic [31:0]   prev_awaddr;
   logic [DW-1:0] prev_wdata;
   logic          prev_wlast;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fifo_q.delete(); exp_w.delete(); aw_log.delete();
      aw_hs_cnt = 0; w_hs_cnt = 0; b_hs_cnt = 0; beats_in_burst = 0;
      bubble_left = 0; pop_pend = 0; last_pend = 0; b_hs_pend = 0;
      outstanding = 0; model_err = 1'b0; prev_aw_stall = 0; prev_w_stall = 0;
   endtask

   task automatic push_words(input int n);
      for (int i = 0; i < n; i++) begin
         logic [FW-1:0] w;
         w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         fifo_q.push_back(w);
         exp_w.push_back(DW'(w));
      end
   endtask

   task automatic wait_bursts(input int n, input int budget, input string name);
      int c = 0;
      while (b_hs_cnt < n && c < budget) begin @(negedge clk); c++; end
      check(name, b_hs_cnt, n);
   endtask

   task automatic wait_beats(input int n, input string name);
      int c = 0;
      while (w_hs_cnt < n && c < 200) begin @(negedge clk); c++; end
      check(name, w_hs_cnt, n);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ctrl_wr_en = 1'b0; model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // FIFO and AXI slave driver: acts just after the falling edge.
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
         fifo_empty = 1'b1; fifo_dout = '0; fifo_rd_data_count = '0;
         aw_wait = 0; b_wait = 0; b_active = 0;
      end else begin
         if (pop_pend) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_pend = 0;
         end
         if (b_hs_pend) begin b_hs_pend = 0; b_active = 0; bvalid = 1'b0; end
         if (last_pend) begin last_pend = 0; b_active = 1; b_wait = 0; end
         if (b_active && !bvalid) begin
            if (b_wait >= b_delay) begin
               bvalid = 1'b1;
               bresp  = (b_hs_cnt + 1 == err_burst) ? 2'b10 : 2'b00;
            end else b_wait++;
         end
         if (!awvalid) begin aw_wait = 0; awready = (aw_delay == 0); end
         else begin awready = (aw_wait >= aw_delay); aw_wait++; end
         case (wready_mode)
            0:       wready = 1'b1;
            1:       wready = ~wready;
            default: wready = 1'($urandom_range(0, 1));
         endcase
         fifo_empty = (fifo_q.size() == 0) || (bubble_left > 0);
         if (bubble_left > 0) bubble_left--;
         fifo_dout = (fifo_q.size() > 0) ? fifo_q[0] : '0;
         fifo_rd_data_count = 10'(fifo_q.size());
      end
   end

   // Monitor: samples 1 ns before the rising edge, compares against the model.
   always @(negedge clk) begin
      #4;
      if (rst_n) begin
         check("rd_en_eq_hs", fifo_rd_en, wvalid & wready);
         check("burst_cnt", wr_burst_cnt, 32'(b_hs_cnt));
         check("bresp_err", bresp_err, model_err);
         if (fifo_empty) check("wvalid_when_empty", wvalid, 1'b0);
         if (awvalid) check("one_outstanding", outstanding, 1'b0);
         if (prev_aw_stall) begin
            check("aw_hold_valid", awvalid, 1'b1);
            check("aw_hold_addr", awaddr, prev_awaddr);
         end
         if (prev_w_stall) begin
            check("w_hold_valid", wvalid, 1'b1);
            check("w_hold_data", wdata, prev_wdata);
            check("w_hold_last", wlast, prev_wlast);
         end
         if (awvalid && awready) begin
            check("awaddr", awaddr, BASE + (32'(aw_hs_cnt) * BB) % RING);
            check("awlen", awlen, 8'(LEN - 1));
            check("awsize", awsize, 3'd5);
            check("awburst", awburst, 2'b01);
            aw_log.push_back(awaddr);
            aw_hs_cnt++; outstanding = 1; beats_in_burst = 0;
         end
         if (wvalid && wready) begin
            check("w_after_aw", outstanding, 1'b1);
            if (exp_w.size() == 0) check("w_unexpected_beat", 1'b1, 1'b0);
            else check("wdata_order", wdata, exp_w.pop_front());
            check("wstrb", wstrb, 32'hFFFF_FFFF);
            check("wlast", wlast, beats_in_burst == LEN - 1);
            beats_in_burst++; w_hs_cnt++; pop_pend = 1;
            if (beats_in_burst == LEN) last_pend = 1;
         end
         if (bvalid && bready) begin
            check("beats_per_burst", beats_in_burst, LEN);
            b_hs_cnt++; model_err = model_err | (bresp != 2'b00);
            b_hs_pend = 1; outstanding = 0;
         end
         prev_aw_stall = awvalid && !awready; prev_awaddr = awaddr;
         prev_w_stall  = wvalid && !wready;   prev_wdata  = wdata; prev_wlast = wlast;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, a0, b0;
      aw_delay = 0; b_delay = 0; wready_mode = 0; err_burst = 0;
      model_reset();
      repeat (3) @(negedge clk);
      #2;
      check("rst_awvalid", awvalid, 1'b0);   check("rst_wvalid", wvalid, 1'b0);
      check("rst_wlast", wlast, 1'b0);       check("rst_bready", bready, 1'b0);
      check("rst_busy", busy, 1'b0);         check("rst_rd_en", fifo_rd_en, 1'b0);
      check("rst_cnt", wr_burst_cnt, 32'd0); check("rst_err", bresp_err, 1'b0);
      check("rst_awaddr", awaddr, 32'd0);    check("rst_wstrb", wstrb, 32'd0);
      check("rst_awlen", awlen, 8'd15);      check("rst_awsize", awsize, 3'd5);
      check("rst_awburst", awburst, 2'b01);
      @(negedge clk); rst_n = 1'b1;

      // Basic burst: latency and minimum period
      @(negedge clk);
      push_words(16); ctrl_wr_en = 1'b1;
      #2 check("t1_aw_before", awvalid, 1'b0);
      @(negedge clk); #2;
      check("t1_aw_rise", awvalid, 1'b1); check("t1_awaddr", awaddr, BASE);
      check("t1_busy", busy, 1'b1);
      repeat (16) @(negedge clk);
      #2 check("t1_beats_15", w_hs_cnt, 15);
      @(negedge clk); #2;
      check("t1_beats_16", w_hs_cnt, 16); check("t1_cnt_18", wr_burst_cnt, 32'd0);
      @(negedge clk); #2;
      check("t1_cnt_19", wr_burst_cnt, 32'd1); check("t1_idle", busy, 1'b0);

      // Ring wrap over three bursts
      do_reset();
      @(negedge clk); push_words(48); ctrl_wr_en = 1'b1;
      wait_bursts(3, 200, "t2_bursts");
      check("t2_log_size", aw_log.size(), 3);
      if (aw_log.size() >= 3) begin
         check("t2_addr0", aw_log[0], BASE);
         check("t2_addr1", aw_log[1], BASE + BB);
         check("t2_addr2", aw_log[2], BASE);
      end

      // Back-pressure on all channels
      aw_delay = 5; wready_mode = 1; b_delay = 7;
      @(negedge clk); push_words(32);
      wait_bursts(5, 400, "t3_bursts");
      aw_delay = 0; wready_mode = 0; b_delay = 0;

      // Start threshold and enable drop mid-burst
      @(negedge clk); a0 = aw_hs_cnt; push_words(15);
      repeat (10) @(negedge clk);
      #2 check("t4_no_aw_15", aw_hs_cnt, a0); check("t4_awvalid_15", awvalid, 1'b0);
      @(negedge clk); push_words(17); w0 = w_hs_cnt; b0 = b_hs_cnt;
      wait_beats(w0 + 4, "t4_started");
      ctrl_wr_en = 1'b0;
      wait_bursts(b0 + 1, 200, "t4_completes");
      repeat (40) @(negedge clk);
      #2 check("t4_no_new_aw", aw_hs_cnt, a0 + 1); check("t4_idle", busy, 1'b0);

      // FIFO underrun bubbles mid-burst
      @(negedge clk); ctrl_wr_en = 1'b1; w0 = w_hs_cnt; b0 = b_hs_cnt;
      wait_beats(w0 + 6, "t5_mid");
      bubble_left = 3;
      wait_bursts(b0 + 1, 200, "t5_completes");
      check("t5_all_beats", w_hs_cnt, w0 + 16);

      // Sticky error response, then reset during W
      do_reset();
      err_burst = 2;
      @(negedge clk); push_words(64); ctrl_wr_en = 1'b1;
      wait_bursts(4, 400, "t6_bursts");
      #2 check("t6_err_sticky", bresp_err, 1'b1); check("t6_cnt", wr_burst_cnt, 32'd4);
      @(negedge clk); err_burst = 0; push_words(16); w0 = w_hs_cnt;
      wait_beats(w0 + 5, "t6_in_w");
      rst_n = 1'b0; ctrl_wr_en = 1'b0; model_reset();
      #2;
      check("t6_rst_awvalid", awvalid, 1'b0); check("t6_rst_wvalid", wvalid, 1'b0);
      check("t6_rst_bready", bready, 1'b0);   check("t6_rst_rd_en", fifo_rd_en, 1'b0);
      check("t6_rst_busy", busy, 1'b0);       check("t6_rst_err", bresp_err, 1'b0);
      check("t6_rst_cnt", wr_burst_cnt, 32'd0);
      repeat (2) @(negedge clk); rst_n = 1'b1;
      @(negedge clk); push_words(16); ctrl_wr_en = 1'b1;
      wait_bursts(1, 200, "t6_recover");

      // Randomized ready/delay/error mix
      for (int it = 0; it < 8; it++) begin
         int k;
         @(negedge clk);
         aw_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 4);
         wready_mode = 2; err_burst = b_hs_cnt + int'($urandom_range(1, 4));
         k = $urandom_range(1, 2); b0 = b_hs_cnt;
         push_words(16 * k);
         wait_bursts(b0 + k, 600, "t7_random");
      end
      ctrl_wr_en = 1'b0; wready_mode = 0;
      repeat (5) @(negedge clk);
      check("end_exp_empty", exp_w.size(), 0);
      check("end_fifo_empty", fifo_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
